// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared addresses, status bit positions and drain FSM states
package uart_tx_buffer_pkg;

  // Default memory-mapped addresses of the transmit buffer
  localparam logic [31:0] UART_TX_ADDR     = 32'h0000_2001;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_2002;

  // Status word layout
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OCC_LSB   = 8;
  localparam int STATUS_OCC_MSB   = 15;

  // Drain FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both sides so a misbehaving caller cannot corrupt the count
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is visible without a read strobe
  assign rdata = mem[rd_ptr];

  // Storage array carries no reset; stale contents are unreachable once count is 0
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - CPU store queue draining into the uart_tx start/ready handshake
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] TX_ADDR     = UART_TX_ADDR,
  parameter logic [31:0] STATUS_ADDR = UART_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_WrData,
  input  logic        data_memwrite,
  input  logic        data_memread,
  output logic [31:0] status_rdata,
  output logic        stall,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready
);

  logic                  tx_sel;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  full;
  logic                  empty;
  logic [7:0]            head;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]            occupancy;
  logic                  unused_wrdata;
  drain_state_t          state;

  // Only the low byte of a store is transmitted
  assign unused_wrdata = ^data_WrData[31:8];

  // Full is taken from the registered count, so a pop in the same cycle does not admit the store
  assign tx_sel    = data_memwrite && (data_addr == TX_ADDR);
  assign stall     = tx_sel && full;
  assign fifo_push = tx_sel && !full;
  assign fifo_pop  = (state == ST_IDLE) && !empty && tx_ready;

  // Occupancy field is 8 bits wide; larger counts are truncated
  assign occupancy = 8'(count);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_WrData[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Status word is driven only during a load from the status address
  always_comb begin
    status_rdata = '0;
    if (data_memread && (data_addr == STATUS_ADDR)) begin
      status_rdata[STATUS_FULL_BIT]                = full;
      status_rdata[STATUS_EMPTY_BIT]               = empty;
      status_rdata[STATUS_BUSY_BIT]                = (state != ST_IDLE);
      status_rdata[STATUS_OCC_MSB:STATUS_OCC_LSB]  = occupancy;
    end
  end

  // Drain FSM: launch the head byte, hold start until uart_tx drops ready, then wait for frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (!tx_ready) begin
            tx_start <= 1'b0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tx_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - scoreboard bench for uart_tx_buffer with a behavioural uart_tx model
module tb_uart_tx_buffer;

  localparam logic [31:0] TXA = 32'h0000_2001;
  localparam logic [31:0] STA = 32'h0000_2002;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_WrData;
  logic        data_memwrite;
  logic        data_memread;
  logic [31:0] status_rdata;
  logic        stall;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         accepted;
  int         launched;

  logic manual;
  int   drop_lat;
  bit   rand_lat;
  bit   armed;
  int   pend;
  int   frame_left;

  logic       prev_start;
  logic [7:0] held;

  int          ns;
  int          nst;
  logic [31:0] st;
  logic [7:0]  b;

  uart_tx_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .data_addr     (data_addr),
    .data_WrData   (data_WrData),
    .data_memwrite (data_memwrite),
    .data_memread  (data_memread),
    .status_rdata  (status_rdata),
    .stall         (stall),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_ready      (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // uart_tx stand-in: drops ready some cycles after seeing start, stays busy for a random frame
  always @(negedge clk) begin
    if (!manual) begin
      if (!tx_ready) begin
        if (frame_left == 0) tx_ready = 1'b1;
        else frame_left--;
      end else if (tx_start) begin
        if (!armed) begin
          armed = 1'b1;
          pend = rand_lat ? int'($urandom_range(0, 2)) : drop_lat;
        end
        if (pend == 0) begin
          tx_ready = 1'b0;
          armed = 1'b0;
          frame_left = int'($urandom_range(0, 5));
        end else begin
          pend--;
        end
      end
    end
  end

  // Monitor: every rising tx_start is a launch and must carry the oldest queued byte
  always @(negedge clk) begin
    if (!rst && tx_start && !prev_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL launch_unexpected actual=%h required=none", tx_data);
      end else begin
        check("launch_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        launched++;
      end
      held = tx_data;
    end else if (!rst && tx_start && prev_start) begin
      check("start_hold_data", {24'h0, tx_data}, {24'h0, held});
    end
    prev_start = tx_start;
  end

  task automatic store(input logic [31:0] addr, input logic [7:0] byte_in, output int nstall);
    logic [23:0] junk;
    nstall = 0;
    junk = 24'($urandom());
    @(negedge clk);
    data_addr     = addr;
    data_WrData   = {junk, byte_in};
    data_memwrite = 1'b1;
    #2;
    forever begin
      check("stall_model", {31'h0, stall},
            {31'h0, (addr == TXA) && ((accepted - launched) == 16)});
      if (!stall || nstall > 500) break;
      nstall++;
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    data_memwrite = 1'b0;
    if (addr == TXA && nstall <= 500) begin
      exp_q.push_back(byte_in);
      accepted++;
    end
  endtask

  task automatic read_status(input logic [31:0] addr, output logic [31:0] v);
    @(negedge clk);
    data_addr    = addr;
    data_memread = 1'b1;
    #2;
    v = status_rdata;
    data_memread = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_start || !tx_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
    #2;
    check({name, "_start_low"}, {31'h0, tx_start}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    data_addr = '0;
    data_WrData = '0;
    data_memwrite = 1'b0;
    data_memread = 1'b0;
    tx_ready = 1'b1;
    manual = 1'b1;
    drop_lat = 1;
    rand_lat = 1'b0;
    armed = 1'b0;
    pend = 0;
    frame_left = 0;
    accepted = 0;
    launched = 0;
    prev_start = 1'b0;
    held = 8'h00;
    nst = 0;

    // Reset state
    repeat (3) @(negedge clk);
    data_addr = STA;
    data_memread = 1'b1;
    #2;
    check("rst_status", status_rdata, 32'h2);
    check("rst_start", {31'h0, tx_start}, 0);
    check("rst_data", {24'h0, tx_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    data_memread = 1'b0;

    // Single byte: two-cycle latency, start held until ready drops
    manual = 1'b0;
    drop_lat = 1;
    store(TXA, 8'h41, ns);
    check("t1_nostall", ns, 0);
    #2;
    check("t1_start_n1", {31'h0, tx_start}, 0);
    @(negedge clk); #2;
    check("t1_start_n2", {31'h0, tx_start}, 1);
    check("t1_data", {24'h0, tx_data}, 32'h41);
    @(negedge clk); #2;
    check("t1_start_n3", {31'h0, tx_start}, 1);
    @(negedge clk); #2;
    check("t1_start_fall", {31'h0, tx_start}, 0);
    read_status(STA, st);
    check("t1_empty", {31'h0, st[1]}, 1);
    wait_drain("t1_drain");

    // Fill to 16 with ready held low, then a stalled 17th store
    manual = 1'b1;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      store(TXA, 8'(i), ns);
      nst += ns;
    end
    check("t2_nostall16", nst, 0);
    read_status(STA, st);
    check("t2_count16", {24'h0, st[15:8]}, 16);
    check("t2_full", {31'h0, st[0]}, 1);
    @(negedge clk);
    data_addr = TXA;
    data_WrData = 32'h5A5A_5A10;
    data_memwrite = 1'b1;
    #2;
    check("t2_stall17", {31'h0, stall}, 1);
    @(negedge clk); #2;
    check("t3_stall_held", {31'h0, stall}, 1);
    drop_lat = 0;
    tx_ready = 1'b1;
    manual = 1'b0;
    @(negedge clk); #2;
    check("t3_stall_after_pop", {31'h0, stall}, 0);
    @(negedge clk);
    data_memwrite = 1'b0;
    exp_q.push_back(8'h10);
    accepted++;
    data_addr = STA;
    data_memread = 1'b1;
    #2;
    check("t3_count16", {24'h0, status_rdata[15:8]}, 16);
    data_memread = 1'b0;
    wait_drain("t2_drain");

    // Reset while in START with five bytes still queued
    manual = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) store(TXA, 8'(8'hA0 + i), ns);
    read_status(STA, st);
    check("t4_count5", {24'h0, st[15:8]}, 5);
    check("t4_busy", {31'h0, st[2]}, 1);
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b0;
    data_addr = STA;
    data_memread = 1'b1;
    exp_q.delete();
    accepted = 0;
    launched = 0;
    @(negedge clk); #2;
    check("t4_start_rst", {31'h0, tx_start}, 0);
    check("t4_status_rst", status_rdata, 32'h2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("t4_no_launch", {31'h0, tx_start}, 0);
    end
    data_memread = 1'b0;
    frame_left = 0;
    manual = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("t4_idle", {31'h0, tx_start}, 0);

    // Random traffic across several pointer wraps
    rand_lat = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom());
      store(TXA, b, ns);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i % 8 == 7) begin
        read_status(STA, st);
        check("t5_count", {24'h0, st[15:8]}, accepted - launched);
        check("t5_bound", {31'h0, st[15:8] <= 8'd16}, 1);
      end
    end
    wait_drain("t5_drain");

    // Other addresses have no side effects
    store(32'h0000_2000, 8'h77, ns);
    check("t6_nostall", ns, 0);
    repeat (6) @(negedge clk);
    read_status(STA, st);
    check("t6_status", st, 32'h2);
    read_status(TXA, st);
    check("t6_other_read", st, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
